// File: rtl/divider_pkg.sv
// Shared types and defaults for the shift-subtract divider.
package divider_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;
  localparam int DIV_WIDTH_DEFAULT = 8;
endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial subtract, keep or restore.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   p,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   p_next,
  output logic             q_bit,
  output logic             borrow
);
  logic [WIDTH:0] shifted, t;
  // P never exceeds D after a step, so its top bit is always 0 going in
  logic unused_p_msb;

  assign unused_p_msb = p[WIDTH];
  assign shifted      = {p[WIDTH-1:0], q_msb};
  assign t            = shifted - {1'b0, d};
  assign borrow       = t[WIDTH];
  assign q_bit        = ~t[WIDTH];
  assign p_next       = t[WIDTH] ? shifted : t;
endmodule

// File: rtl/shift_sub_divider.sv
// Sequential restoring divider, one step per clock for WIDTH clocks.
// DIV_SIGNED_EN: two's-complement operands/results (truncating), same latency.
module shift_sub_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   p, p_step;
  logic [WIDTH-1:0] q, d, q_step;
  logic             q_bit, borrow, unused_borrow;
  logic             last_step, div_zero;
  logic [WIDTH-1:0] dvd_abs, dvs_abs, q_fin, r_fin;

  assign div_zero      = (Divisor == '0);
  assign last_step     = (cnt == CNT_W'(WIDTH - 1));
  assign unused_borrow = borrow;

  div_step #(.WIDTH(WIDTH)) u_step (
    .p      (p),
    .q_msb  (q[WIDTH-1]),
    .d      (d),
    .p_next (p_step),
    .q_bit  (q_bit),
    .borrow (borrow)
  );

  assign q_step = {q[WIDTH-2:0], q_bit};

`ifdef DIV_SIGNED_EN
  logic sgn_a, sgn_b;
  // Core runs on magnitudes; most-negative stays as its own unsigned magnitude
  assign dvd_abs = Dividend[WIDTH-1] ? -Dividend : Dividend;
  assign dvs_abs = Divisor[WIDTH-1]  ? -Divisor  : Divisor;
  assign q_fin   = (sgn_a ^ sgn_b) ? -q_step : q_step;
  assign r_fin   = sgn_a ? -p_step[WIDTH-1:0] : p_step[WIDTH-1:0];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sgn_a <= 1'b0;
      sgn_b <= 1'b0;
    end else if (state == IDLE && Start && !div_zero) begin
      sgn_a <= Dividend[WIDTH-1];
      sgn_b <= Divisor[WIDTH-1];
    end
  end
`else
  assign dvd_abs = Dividend;
  assign dvs_abs = Divisor;
  assign q_fin   = q_step;
  assign r_fin   = p_step[WIDTH-1:0];
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      IDLE: if (Start) state_nxt = div_zero ? DONE : RUN;
      RUN: begin
        Busy = 1'b1;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        Done = 1'b1;
        if (!Start) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      p         <= '0;
      q         <= '0;
      d         <= '0;
      cnt       <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      DivByZero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          if (!div_zero) begin
            p   <= '0;
            q   <= dvd_abs;
            d   <= dvs_abs;
            cnt <= '0;
          end else begin
            Quotient  <= '1;
            Remainder <= Dividend;
            DivByZero <= 1'b1;
          end
        end
        RUN: begin
          p   <= p_step;
          q   <= q_step;
          cnt <= cnt + 1'b1;
          // results load on the same edge that completes the last step
          if (last_step) begin
            Quotient  <= q_fin;
            Remainder <= r_fin;
            DivByZero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
